// File: rtl/money_pkg.sv
// Shared ledger types and widths, used by the ledger, display stage and game FSM.
package money_pkg;

    localparam int unsigned MONEY_W           = 16;
    localparam int unsigned MAX_MONEY_DEFAULT = 10000;

    typedef enum logic [1:0] {
        IDLE,
        LOCKED,
        SETTLE
    } ledger_state_e;

endpackage

// File: rtl/money_sat_add.sv
// Combinational add with clamp to a ceiling; the sum is formed one bit wider so it cannot wrap.
module money_sat_add
    import money_pkg::*;
(
    input  logic [MONEY_W-1:0] a,
    input  logic [MONEY_W-1:0] b,
    input  logic [MONEY_W-1:0] ceiling,
    output logic [MONEY_W-1:0] sum
);

    logic [MONEY_W:0] full;

    assign full = {1'b0, a} + {1'b0, b};
    assign sum  = (full > {1'b0, ceiling}) ? ceiling : full[MONEY_W-1:0];

endmodule

// File: rtl/money_ledger.sv
// Player balance and bet ledger: place / hold / settle, balance saturated to 0..MAX_MONEY.
// Define LEDGER_STATS_EN to add saturating win_count / loss_count outputs.
module money_ledger
    import money_pkg::*;
#(
    parameter int unsigned INIT_MONEY   = 1000,
    parameter int unsigned MAX_MONEY    = MAX_MONEY_DEFAULT,
    parameter int unsigned DEPOSIT_STEP = 100,
    parameter int unsigned BET_STEP     = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               deposit_p,
    input  logic               bet_up_p,
    input  logic               bet_down_p,
    input  logic               bet_place_p,
    input  logic               result_valid,
    input  logic               result_win,
    input  logic [1:0]         payout_mult,
    output logic [MONEY_W-1:0] current_money,
    output logic [MONEY_W-1:0] bet_amount,
    output logic               bet_locked,
    output logic               bet_reject,
    output logic               broke
`ifdef LEDGER_STATS_EN
    ,
    output logic [7:0]         win_count,
    output logic [7:0]         loss_count
`endif
);

    localparam logic [MONEY_W-1:0] INIT_V = MONEY_W'(INIT_MONEY);
    localparam logic [MONEY_W-1:0] MAX_V  = MONEY_W'(MAX_MONEY);
    localparam logic [MONEY_W-1:0] DEP_V  = MONEY_W'(DEPOSIT_STEP);
    localparam logic [MONEY_W-1:0] BET_V  = MONEY_W'(BET_STEP);

    ledger_state_e      state;
    logic               win_q;
    logic [1:0]         mult_q;

    logic [MONEY_W-1:0] dep_sum;
    logic [MONEY_W-1:0] pay_sum;
    logic [MONEY_W-1:0] payout;
    logic [MONEY_W-1:0] settle_money;
    logic [2:0]         mult_p1;
    logic [MONEY_W+2:0] product;
    logic               bet_up_ok;

    assign mult_p1 = {1'b0, mult_q} + 3'd1;
    assign product = {3'b000, bet_amount} * {{MONEY_W{1'b0}}, mult_p1};
    // Clamp the product first so an oversized bet can never wrap into the adder.
    assign payout  = (product > {3'b000, MAX_V}) ? MAX_V : product[MONEY_W-1:0];

    assign bet_up_ok    = ({1'b0, bet_amount} + {1'b0, BET_V}) <= {1'b0, current_money};
    assign settle_money = win_q ? pay_sum : current_money;

    money_sat_add u_dep_add (
        .a       (current_money),
        .b       (DEP_V),
        .ceiling (MAX_V),
        .sum     (dep_sum)
    );

    money_sat_add u_pay_add (
        .a       (current_money),
        .b       (payout),
        .ceiling (MAX_V),
        .sum     (pay_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            current_money <= INIT_V;
            bet_amount    <= BET_V;
            bet_locked    <= 1'b0;
            bet_reject    <= 1'b0;
            broke         <= (INIT_V == '0);
            win_q         <= 1'b0;
            mult_q        <= 2'd0;
`ifdef LEDGER_STATS_EN
            win_count     <= 8'd0;
            loss_count    <= 8'd0;
`endif
        end else begin
            bet_reject <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bet_place_p) begin
                        if (current_money != '0 && bet_amount <= current_money) begin
                            current_money <= current_money - bet_amount;
                            broke         <= (current_money == bet_amount);
                            bet_locked    <= 1'b1;
                            state         <= LOCKED;
                        end else begin
                            bet_reject <= 1'b1;
                        end
                    end else if (deposit_p) begin
                        current_money <= dep_sum;
                        broke         <= (dep_sum == '0);
                    end else if (bet_up_p && !bet_down_p) begin
                        if (bet_up_ok) begin
                            bet_amount <= bet_amount + BET_V;
                        end
                    end else if (bet_down_p && !bet_up_p) begin
                        if (bet_amount > BET_V) begin
                            bet_amount <= bet_amount - BET_V;
                        end
                    end
                end
                LOCKED: begin
                    if (result_valid) begin
                        win_q  <= result_win;
                        mult_q <= payout_mult;
                        state  <= SETTLE;
                    end
                end
                SETTLE: begin
                    current_money <= settle_money;
                    broke         <= (settle_money == '0);
                    if (bet_amount > settle_money) begin
                        bet_amount <= BET_V;
                    end
                    bet_locked <= 1'b0;
                    state      <= IDLE;
`ifdef LEDGER_STATS_EN
                    if (win_q && win_count != 8'hff) begin
                        win_count <= win_count + 8'd1;
                    end
                    if (!win_q && loss_count != 8'hff) begin
                        loss_count <= loss_count + 8'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_money_ledger.sv
// Self-checking bench for money_ledger: directed scenarios plus randomized run against a model.
module tb_money_ledger;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        deposit_p = 1'b0;
    logic        bet_up_p = 1'b0;
    logic        bet_down_p = 1'b0;
    logic        bet_place_p = 1'b0;
    logic        result_valid = 1'b0;
    logic        result_win = 1'b0;
    logic [1:0]  payout_mult = 2'd0;
    logic [15:0] current_money;
    logic [15:0] bet_amount;
    logic        bet_locked;
    logic        bet_reject;
    logic        broke;
`ifdef LEDGER_STATS_EN
    logic [7:0]  win_count;
    logic [7:0]  loss_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: balance, bet, held-stake flag, pending credit.
    int m_money;
    int m_bet;
    bit m_holding;
    bit m_resolving;
    bit m_reject;
    bit m_win;
    int m_mult;

    always #5 clk = ~clk;

    money_ledger dut (
        .clk           (clk),
        .rst           (rst),
        .deposit_p     (deposit_p),
        .bet_up_p      (bet_up_p),
        .bet_down_p    (bet_down_p),
        .bet_place_p   (bet_place_p),
        .result_valid  (result_valid),
        .result_win    (result_win),
        .payout_mult   (payout_mult),
        .current_money (current_money),
        .bet_amount    (bet_amount),
        .bet_locked    (bet_locked),
        .bet_reject    (bet_reject),
        .broke         (broke)
`ifdef LEDGER_STATS_EN
        ,
        .win_count     (win_count),
        .loss_count    (loss_count)
`endif
    );

    task automatic model_step(input bit r, input bit dep, input bit up, input bit dn,
                              input bit pl, input bit rv, input bit w, input int m);
        if (r) begin
            m_money = 1000; m_bet = 100; m_holding = 0; m_resolving = 0; m_reject = 0;
            return;
        end
        m_reject = 0;
        if (m_resolving) begin
            if (m_win) m_money = (m_money + m_bet * (m_mult + 1) > 10000) ? 10000
                                 : m_money + m_bet * (m_mult + 1);
            if (m_bet > m_money) m_bet = 100;
            m_holding = 0;
            m_resolving = 0;
        end else if (m_holding) begin
            if (rv) begin
                m_resolving = 1; m_win = w; m_mult = m;
            end
        end else if (pl) begin
            if (m_money != 0 && m_bet <= m_money) begin
                m_money -= m_bet; m_holding = 1;
            end else begin
                m_reject = 1;
            end
        end else if (dep) begin
            m_money = (m_money + 100 > 10000) ? 10000 : m_money + 100;
        end else if (up && !dn) begin
            if (m_bet + 100 <= m_money) m_bet += 100;
        end else if (dn && !up) begin
            if (m_bet > 100) m_bet -= 100;
        end
    endtask

    // Drive one clock of inputs, then sample 1 ns after the edge.
    task automatic cycle(input bit dep, input bit up, input bit dn, input bit pl,
                         input bit rv, input bit w, input logic [1:0] m);
        deposit_p = dep; bet_up_p = up; bet_down_p = dn; bet_place_p = pl;
        result_valid = rv; result_win = w; payout_mult = m;
        @(posedge clk);
        #1;
        model_step(rst, dep, up, dn, pl, rv, w, int'(m));
        deposit_p = 0; bet_up_p = 0; bet_down_p = 0; bet_place_p = 0;
        result_valid = 0; result_win = 0; payout_mult = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 2'd0);
    endtask

    task automatic apply_reset();
        rst = 1;
        cycle(0, 0, 0, 0, 0, 0, 2'd0);
        rst = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (current_money !== 16'd1000) begin
            n_err++; $display("FAIL reset_money: got %0d want 1000", current_money);
        end
        n_cmp++;
        if (bet_amount !== 16'd100) begin
            n_err++; $display("FAIL reset_bet: got %0d want 100", bet_amount);
        end
        n_cmp++;
        if (bet_locked !== 1'b0 || broke !== 1'b0 || bet_reject !== 1'b0) begin
            n_err++; $display("FAIL reset_flags: got locked=%b broke=%b reject=%b want 0 0 0",
                              bet_locked, broke, bet_reject);
        end
    endtask

    task automatic test_win_round();
        apply_reset();
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 0, 2'd0);
        n_cmp++;
        if (bet_amount !== 16'd400) begin
            n_err++; $display("FAIL win_bet_up: got %0d want 400", bet_amount);
        end
        cycle(0, 0, 0, 1, 0, 0, 2'd0);
        n_cmp++;
        if (current_money !== 16'd600 || bet_locked !== 1'b1) begin
            n_err++; $display("FAIL win_place: got money=%0d locked=%b want 600 1",
                              current_money, bet_locked);
        end
        cycle(0, 0, 0, 0, 1, 1, 2'd2);
        n_cmp++;
        if (current_money !== 16'd600 || bet_locked !== 1'b1) begin
            n_err++; $display("FAIL win_settle_early: got money=%0d locked=%b want 600 1",
                              current_money, bet_locked);
        end
        idle(1);
        n_cmp++;
        if (current_money !== 16'd1800 || bet_locked !== 1'b0) begin
            n_err++; $display("FAIL win_credit: got money=%0d locked=%b want 1800 0",
                              current_money, bet_locked);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 90; i++) cycle(1, 0, 0, 0, 0, 0, 2'd0);
        n_cmp++;
        if (current_money !== 16'd10000) begin
            n_err++; $display("FAIL sat_deposit: got %0d want 10000", current_money);
        end
        cycle(1, 0, 0, 0, 0, 0, 2'd0);
        n_cmp++;
        if (current_money !== 16'd10000) begin
            n_err++; $display("FAIL sat_deposit_over: got %0d want 10000", current_money);
        end
        for (int i = 0; i < 100; i++) cycle(0, 1, 0, 0, 0, 0, 2'd0);
        n_cmp++;
        if (bet_amount !== 16'd10000) begin
            n_err++; $display("FAIL sat_bet_cap: got %0d want 10000", bet_amount);
        end
        cycle(0, 0, 0, 1, 0, 0, 2'd0);
        n_cmp++;
        if (current_money !== 16'd0 || broke !== 1'b1) begin
            n_err++; $display("FAIL sat_all_in: got money=%0d broke=%b want 0 1",
                              current_money, broke);
        end
        cycle(0, 0, 0, 0, 1, 1, 2'd3);
        idle(1);
        n_cmp++;
        if (current_money !== 16'd10000 || broke !== 1'b0 || bet_amount !== 16'd10000) begin
            n_err++; $display("FAIL sat_payout: got money=%0d broke=%b bet=%0d want 10000 0 10000",
                              current_money, broke, bet_amount);
        end
    endtask

    task automatic test_loss_broke();
        apply_reset();
        for (int i = 0; i < 9; i++) cycle(0, 1, 0, 0, 0, 0, 2'd0);
        cycle(0, 0, 0, 1, 0, 0, 2'd0);
        cycle(0, 0, 0, 0, 1, 0, 2'd1);
        idle(1);
        n_cmp++;
        if (current_money !== 16'd0 || broke !== 1'b1 || bet_amount !== 16'd100) begin
            n_err++; $display("FAIL loss_broke: got money=%0d broke=%b bet=%0d want 0 1 100",
                              current_money, broke, bet_amount);
        end
        cycle(0, 0, 0, 1, 0, 0, 2'd0);
        n_cmp++;
        if (bet_reject !== 1'b1 || current_money !== 16'd0 || bet_locked !== 1'b0) begin
            n_err++; $display("FAIL loss_reject: got reject=%b money=%0d locked=%b want 1 0 0",
                              bet_reject, current_money, bet_locked);
        end
        idle(1);
        n_cmp++;
        if (bet_reject !== 1'b0) begin
            n_err++; $display("FAIL loss_reject_width: got reject=%b want 0", bet_reject);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        cycle(1, 0, 0, 1, 0, 0, 2'd0);
        n_cmp++;
        if (current_money !== 16'd900 || bet_locked !== 1'b1) begin
            n_err++; $display("FAIL simul_place_dep: got money=%0d locked=%b want 900 1",
                              current_money, bet_locked);
        end
        cycle(1, 1, 0, 0, 0, 0, 2'd0);
        n_cmp++;
        if (current_money !== 16'd900 || bet_amount !== 16'd100) begin
            n_err++; $display("FAIL locked_ignore: got money=%0d bet=%0d want 900 100",
                              current_money, bet_amount);
        end
        cycle(0, 0, 0, 0, 1, 0, 2'd0);
        idle(1);
        n_cmp++;
        if (current_money !== 16'd900 || bet_locked !== 1'b0) begin
            n_err++; $display("FAIL simul_loss: got money=%0d locked=%b want 900 0",
                              current_money, bet_locked);
        end
    endtask

    task automatic test_reset_mid_round();
        apply_reset();
        cycle(0, 1, 0, 0, 0, 0, 2'd0);
        cycle(0, 0, 0, 1, 0, 0, 2'd0);
        apply_reset();
        n_cmp++;
        if (current_money !== 16'd1000 || bet_amount !== 16'd100 || bet_locked !== 1'b0) begin
            n_err++; $display("FAIL mid_reset: got money=%0d bet=%0d locked=%b want 1000 100 0",
                              current_money, bet_amount, bet_locked);
        end
        cycle(0, 0, 0, 0, 1, 1, 2'd3);
        idle(2);
        n_cmp++;
        if (current_money !== 16'd1000 || bet_locked !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_result: got money=%0d locked=%b want 1000 0",
                              current_money, bet_locked);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 5) == 0,
                  ($urandom % 6) == 0, ($urandom % 3) == 0, ($urandom % 2) == 0,
                  2'($urandom));
            n_cmp++;
            if (current_money !== 16'(m_money) || bet_amount !== 16'(m_bet)
                || bet_locked !== m_holding || bet_reject !== m_reject
                || broke !== (m_money == 0)) begin
                n_err++;
                $display("FAIL random[%0d]: got money=%0d bet=%0d locked=%b reject=%b broke=%b want %0d %0d %b %b %b",
                         i, current_money, bet_amount, bet_locked, bet_reject, broke,
                         m_money, m_bet, m_holding, m_reject, m_money == 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_win_round();
        test_saturation();
        test_loss_broke();
        test_simultaneous();
        test_reset_mid_round();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/money_ledger.md
Name: money_ledger

Overview:
Owns the player's balance and feeds `current_money` directly to the 5-digit seven-segment display stage downstream.
- Accepts debounced one-cycle button pulses for deposit, bet adjust and bet place.
- Holds the stake while the game FSM resolves a round, then credits any payout.
- Keeps the balance saturated to the 0..MAX_MONEY range, so the display never sees an out-of-range value.

Parameters:
- INIT_MONEY, 1000: balance after reset.
- MAX_MONEY, 10000: saturation ceiling for the balance.
- DEPOSIT_STEP, 100: amount added per deposit pulse.
- BET_STEP, 100: bet increment/decrement and minimum bet.

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous reset, active-high
- deposit_p  in  1  one-cycle pulse: add DEPOSIT_STEP
- bet_up_p  in  1  one-cycle pulse: raise bet by BET_STEP
- bet_down_p  in  1  one-cycle pulse: lower bet by BET_STEP
- bet_place_p  in  1  one-cycle pulse: commit bet
- result_valid  in  1  one-cycle pulse from game FSM: round resolved
- result_win  in  1  valid with result_valid: 1 = win
- payout_mult  in  2  valid with result_valid: win returns stake*(payout_mult+1)
- current_money  out  16  registered balance, 0..MAX_MONEY
- bet_amount  out  16  registered current bet
- bet_locked  out  1  high while a stake is held
- bet_reject  out  1  one-cycle pulse: place refused
- broke  out  1  registered, high when current_money==0

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset state: IDLE; current_money=INIT_MONEY; bet_amount=BET_STEP; bet_locked=0; bet_reject=0; broke=(INIT_MONEY==0).
- Reset asserted mid-round, in any state, forfeits the held stake and restores the reset values.
- FSM states: IDLE, LOCKED, SETTLE.
- IDLE, per-cycle priority (lower-priority pulses in the same cycle are dropped): bet_place_p > deposit_p > bet adjust.
  - Place, accepted when current_money!=0 and bet_amount<=current_money:
    - current_money -= bet_amount and bet_locked=1, both visible at cycle N+1.
    - Next state LOCKED.
  - Place, refused: bet_reject high for exactly cycle N+1; no other change.
  - deposit_p: current_money = min(current_money+DEPOSIT_STEP, MAX_MONEY).
  - bet_up_p alone: increase by BET_STEP only if the result is <= current_money; otherwise hold.
  - bet_down_p alone: decrease only if bet_amount > BET_STEP; floor is BET_STEP.
  - bet_up_p and bet_down_p together: no change.
  - result_valid in IDLE is ignored.
- LOCKED:
  - All button pulses are ignored.
  - result_valid at cycle N: latch result_win and payout_mult; next state SETTLE.
- SETTLE (single cycle), credit computed from the latched values:
  - Win: current_money = min(money + bet_amount*(payout_mult+1), MAX_MONEY).
  - Loss: no credit.
  - If bet_amount > new balance, set bet_amount = BET_STEP.
  - bet_locked=0; next state IDLE.
  - Result timing: result_valid at cycle N gives the updated current_money and bet_locked=0 at cycle N+2.
- Arithmetic:
  - Payout product is at most 10000*4=40000; compute the sum at 17 bits, then saturate to MAX_MONEY.
  - Subtraction never underflows, guaranteed by the place check.
- broke updates in the same cycle as current_money and always equals (current_money==0).

Optional Feature:
- Macro LEDGER_STATS_EN.
- Defined: adds outputs win_count[7:0] and loss_count[7:0].
  - Each increments in the SETTLE cycle of a win or loss respectively.
  - Each saturates at 255; reset to 0.
- Undefined: neither port nor counter exists; behaviour otherwise identical.

Decomposition:
- Package money_pkg:
  - MONEY_W=16 and the MAX_MONEY default.
  - The ledger state enum (IDLE/LOCKED/SETTLE).
  - Shared by the display stage and the game FSM.
- Sub-module money_sat_add: combinational 17-bit add with clamp to a ceiling. Reused for the deposit and payout paths.

Test Plan:
- Reset: after rst high, current_money=1000, bet_amount=100, bet_locked=0, broke=0.
- Win round:
  - Stimulus: 3 bet_up_p, then bet_place_p at cycle N, then result_valid with win=1, mult=2.
  - bet becomes 400.
  - Cycle N+1: money=600, locked=1.
  - Result: money=1800 two cycles after result_valid, locked=0.
- Saturation: 90 deposit_p from 1000 → 10000; a further deposit_p → stays 10000. A win with bet 10000, mult=3 → stays 10000.
- Loss to broke:
  - Stimulus: bet set to 1000, place, result_valid with win=0.
  - Response: money=0, broke=1, bet resets to 100.
  - A further bet_place_p → bet_reject pulse for 1 cycle; money stays 0, locked=0.
- Simultaneous events and ignored pulses:
  - bet_place_p with deposit_p in the same IDLE cycle at 1000/bet 100 → money=900, locked=1 (deposit dropped).
  - deposit_p during LOCKED → ignored.
- Reset mid-LOCKED → money=1000, bet=100, locked=0; a later result_valid is ignored.
